// File: rtl/mplier_arb2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mplier_arb2_pkg
// Description : Shared widths and types for the two-requester pipelined
//               32x32 signed multiplier and its sub-blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package mplier_arb2_pkg;

    localparam int c_OPND_W  = 32;
    localparam int c_PROD_W  = 64;
    localparam int c_NUM_REQ = 2;
    localparam int c_TAG_W   = $clog2(c_NUM_REQ);

    typedef logic [c_OPND_W-1:0] opnd_t;
    typedef logic [c_PROD_W-1:0] prod_t;
    typedef logic [c_TAG_W-1:0]  tag_t;

endpackage : mplier_arb2_pkg
`default_nettype wire

// File: rtl/mplier32x32.sv
`default_nettype none
// ============================================================================
// Module      : mplier32x32
// Description : Combinational 32x32 -> 64 signed multiplier. Radix-4 Booth
//               recoding of the multiplier, a Wallace tree of 3:2 carry-save
//               compressors, and a final carry-propagate adder.
// Revision    : 1.0 - initial release
// ============================================================================
module mplier32x32
    import mplier_arb2_pkg::*;
(
    input  opnd_t i_mplier,
    input  opnd_t i_mcand,
    output prod_t o_product
);

    // One partial product per radix-4 Booth digit.
    localparam int c_NUM_PP     = c_OPND_W / 2;
    // 16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2 rows.
    localparam int c_NUM_LAYERS = 6;

    prod_t w_pp [c_NUM_PP];
    prod_t w_sum_row;
    prod_t w_carry_row;

    // Booth recoding: each digit in {-2,-1,0,+1,+2} selects a multiple of the
    // sign-extended multiplicand, weighted by 4^i. Working modulo 2^64 keeps
    // the -2^31 operand exact because the true product always fits in 64 bits.
    always_comb begin
        logic [c_OPND_W:0] v_y_ext;
        prod_t             v_a_ext;
        prod_t             v_sel;
        logic [2:0]        v_dig;
        v_y_ext = {i_mplier, 1'b0};
        v_a_ext = {{(c_PROD_W-c_OPND_W){i_mcand[c_OPND_W-1]}}, i_mcand};
        for (int i = 0; i < c_NUM_PP; i++) begin
            v_dig = v_y_ext[2*i +: 3];
            case (v_dig)
                3'b001, 3'b010: v_sel = v_a_ext;
                3'b011:         v_sel = v_a_ext << 1;
                3'b100:         v_sel = -(v_a_ext << 1);
                3'b101, 3'b110: v_sel = -v_a_ext;
                default:        v_sel = '0;
            endcase
            w_pp[i] = v_sel << (2*i);
        end
    end

    // Wallace reduction: every full group of three rows becomes a sum row and
    // a shifted carry row; leftover rows pass straight to the next layer.
    always_comb begin
        prod_t v_rows [c_NUM_PP];
        prod_t v_nxt  [c_NUM_PP];
        int    v_n;
        int    v_m;
        v_rows = w_pp;
        v_n    = c_NUM_PP;
        for (int k = 0; k < c_NUM_LAYERS; k++) begin
            v_m = 0;
            for (int j = 0; j < c_NUM_PP; j++) begin
                v_nxt[j] = '0;
            end
            for (int g = 0; g < c_NUM_PP/3; g++) begin
                if (3*g + 2 < v_n) begin
                    v_nxt[v_m]   = v_rows[3*g] ^ v_rows[3*g+1] ^ v_rows[3*g+2];
                    v_nxt[v_m+1] = ((v_rows[3*g]   & v_rows[3*g+1]) |
                                    (v_rows[3*g]   & v_rows[3*g+2]) |
                                    (v_rows[3*g+1] & v_rows[3*g+2])) << 1;
                    v_m = v_m + 2;
                end
            end
            for (int j = 0; j < c_NUM_PP; j++) begin
                if ((j >= 3*(v_n/3)) && (j < v_n)) begin
                    v_nxt[v_m] = v_rows[j];
                    v_m = v_m + 1;
                end
            end
            v_rows = v_nxt;
            v_n    = v_m;
        end
        w_sum_row   = v_rows[0];
        w_carry_row = v_rows[1];
    end

    // Final carry-propagate adder.
    assign o_product = w_sum_row + w_carry_row;

endmodule : mplier32x32
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. The grant is a pure function of
//               the request vector and the pointer; the pointer moves only
//               when the downstream stage actually takes the granted request.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mplier_arb2_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [c_NUM_REQ-1:0] i_req,
    input  logic                 i_accept,
    output logic [c_NUM_REQ-1:0] o_grant
);

    // Pointer names the requester favoured when both are requesting.
    logic r_ptr;

    // Grant: a lone requester always wins; on contention the pointer decides.
    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = r_ptr ? 2'b10 : 2'b01;
        end
    end

    // Pointer: after an accepted grant, favour the requester that lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_accept && (|o_grant)) begin
            r_ptr <= o_grant[0];
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mplier_arb2.sv
`default_nettype none
// ============================================================================
// Module      : mplier_arb2
// Description : Two-requester, round-robin-arbitrated, two-stage pipelined
//               32x32 signed multiplier with valid/ready handshakes on both
//               sides. Stage 1 holds operands and tag, stage 2 the product.
// Revision    : 1.0 - initial release
// ============================================================================
module mplier_arb2
    import mplier_arb2_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [c_NUM_REQ-1:0] req_valid,
    output logic [c_NUM_REQ-1:0] req_ready,
    input  logic [c_OPND_W-1:0]  mplier0,
    input  logic [c_OPND_W-1:0]  mcand0,
    input  logic [c_OPND_W-1:0]  mplier1,
    input  logic [c_OPND_W-1:0]  mcand1,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [c_PROD_W-1:0]  product,
    output logic                 res_tag,
    output logic [1:0]           inflight
);

    logic r_s1_valid;
    opnd_t r_s1_mplier;
    opnd_t r_s1_mcand;
    tag_t  r_s1_tag;

    logic  r_s2_valid;
    prod_t r_s2_product;
    tag_t  r_s2_tag;

    logic                 w_s1_free;
    logic                 w_s2_free;
    logic [c_NUM_REQ-1:0] w_grant;
    logic [c_NUM_REQ-1:0] w_hs;
    tag_t                 w_sel;
    opnd_t                w_sel_mplier;
    opnd_t                w_sel_mcand;
    prod_t                w_mul_product;

    // A stage can take new data if it is empty or its contents move on now.
    assign w_s2_free = !r_s2_valid || res_ready;
    assign w_s1_free = !r_s1_valid || w_s2_free;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    (req_valid),
        .i_accept (w_s1_free),
        .o_grant  (w_grant)
    );

    assign w_hs         = w_grant & {c_NUM_REQ{w_s1_free}};
    assign w_sel        = w_grant[1];
    assign w_sel_mplier = w_sel ? mplier1 : mplier0;
    assign w_sel_mcand  = w_sel ? mcand1  : mcand0;

    // Stage 1: capture the granted operands whenever the stage can advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_mplier <= '0;
            r_s1_mcand  <= '0;
            r_s1_tag    <= '0;
        end else if (w_s1_free) begin
            r_s1_valid <= |w_hs;
            if (|w_hs) begin
                r_s1_mplier <= w_sel_mplier;
                r_s1_mcand  <= w_sel_mcand;
                r_s1_tag    <= w_sel;
            end
        end
    end

    mplier32x32 u_mul (
        .i_mplier  (r_s1_mplier),
        .i_mcand   (r_s1_mcand),
        .o_product (w_mul_product)
    );

    // Stage 2: register the product; hold everything while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid   <= 1'b0;
            r_s2_product <= '0;
            r_s2_tag     <= '0;
        end else if (w_s2_free) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_product <= w_mul_product;
                r_s2_tag     <= r_s1_tag;
            end
        end
    end

    // Outputs are forced to their idle values for as long as reset is held,
    // including the first reset cycle when the stages still hold old data.
    assign req_ready = rst ? '0 : w_hs;
    assign res_valid = r_s2_valid && !rst;
    assign product   = rst ? '0 : r_s2_product;
    assign res_tag   = rst ? 1'b0 : r_s2_tag;
    assign inflight  = rst ? 2'd0 : ({1'b0, r_s1_valid} + {1'b0, r_s2_valid});

endmodule : mplier_arb2
`default_nettype wire
